// File: rtl/cs161_ctrl_pkg.sv
// Shared constants for the cs161 multi-cycle control unit: opcodes, FSM states,
// ALU op classes and the datapath control bundle.
package cs161_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [3:0] ALUOP_ADD   = 4'b0000;
  localparam logic [3:0] ALUOP_SUB   = 4'b0001;
  localparam logic [3:0] ALUOP_RTYPE = 4'b0010;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef struct packed {
    logic       is_r;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       is_addi;
    logic       legal;
  } dec_t;

  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       pc_branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [3:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       pc_write;
    logic       ir_write;
  } ctrl_t;

endpackage

// File: rtl/cs161_main_decoder.sv
// Opcode classifier: maps a 6-bit MIPS opcode onto the instruction classes the
// control FSM sequences.
import cs161_ctrl_pkg::*;

module cs161_main_decoder (
  input  logic [5:0] op,
  output dec_t       dec
);

  always_comb begin
    dec         = '0;
    dec.is_r    = (op == OP_RTYPE);
    dec.is_lw   = (op == OP_LW);
    dec.is_sw   = (op == OP_SW);
    dec.is_beq  = (op == OP_BEQ);
    dec.is_addi = (op == OP_ADDI);
    dec.legal   = dec.is_r | dec.is_lw | dec.is_sw | dec.is_beq | dec.is_addi;
  end

endmodule

// File: rtl/cs161_control_fsm.sv
// Multi-cycle main control for the cs161 MIPS datapath: FETCH/DECODE/EXEC/MEM/WB
// sequencing with memory-ready stalls, retired-instruction counter and sticky illegal flag.
//
// state  | meaning
// FETCH  | read instruction memory; load PC+4 and IR when mem_ready
// DECODE | latch opcode, reject unsupported opcodes
// EXEC   | ALU operation; BEQ resolves and retires here
// MEM    | data memory access for LW/SW, held until mem_ready
// WB     | register file write, retire
import cs161_ctrl_pkg::*;

module cs161_control_fsm #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           instr_op,
  input  logic [5:0]           funct,
  input  logic                 alu_zero,
  input  logic                 mem_ready,
  output logic                 reg_dst,
  output logic                 branch,
  output logic                 pc_branch,
  output logic                 mem_read,
  output logic                 mem_to_reg,
  output logic [3:0]           alu_op,
  output logic                 mem_write,
  output logic                 alu_src,
  output logic                 reg_write,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic [2:0]           state_out,
  output logic [CNT_WIDTH-1:0] instr_retired,
  output logic                 illegal_op
);

  state_t     state_q, state_d;
  logic [5:0] op_q;
  logic [5:0] dec_op;
  dec_t       dec;
  ctrl_t      ctl, ctl_out;
  logic       retire;
  logic       illegal_set;
  logic       unused_funct;

  assign unused_funct = ^funct;

  // DECODE classifies the live opcode; later states use the latched copy
  assign dec_op = (state_q == ST_DECODE) ? instr_op : op_q;

  cs161_main_decoder u_dec (
    .op  (dec_op),
    .dec (dec)
  );

  always_comb begin
    ctl         = '0;
    state_d     = state_q;
    retire      = 1'b0;
    illegal_set = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ctl.mem_read = 1'b1;
        if (mem_ready) begin
          ctl.pc_write = 1'b1;
          ctl.ir_write = 1'b1;
          state_d      = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec.legal) begin
          state_d = ST_EXEC;
        end else begin
          illegal_set = 1'b1;
          state_d     = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (dec.is_r) begin
          ctl.alu_op = ALUOP_RTYPE;
          state_d    = ST_WB;
        end else if (dec.is_beq) begin
          ctl.alu_op    = ALUOP_SUB;
          ctl.branch    = 1'b1;
          ctl.pc_branch = alu_zero;
          retire        = 1'b1;
          state_d       = ST_FETCH;
        end else begin
          ctl.alu_op  = ALUOP_ADD;
          ctl.alu_src = 1'b1;
          state_d     = (dec.is_lw | dec.is_sw) ? ST_MEM : ST_WB;
        end
      end
      ST_MEM: begin
        ctl.alu_op    = ALUOP_ADD;
        ctl.alu_src   = 1'b1;
        ctl.mem_read  = dec.is_lw;
        ctl.mem_write = ~dec.is_lw;
        if (mem_ready) begin
          if (dec.is_lw) begin
            state_d = ST_WB;
          end else begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = dec.is_r;
        ctl.alu_op     = dec.is_r ? ALUOP_RTYPE : ALUOP_ADD;
        ctl.alu_src    = dec.is_addi;
        ctl.mem_to_reg = dec.is_lw;
        retire         = 1'b1;
        state_d        = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_FETCH;
      op_q          <= '0;
      instr_retired <= '0;
      illegal_op    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) op_q <= instr_op;
      if (retire) instr_retired <= instr_retired + 1'b1;
      if (illegal_set) illegal_op <= 1'b1;
    end
  end

  // reset silences the datapath immediately, before the state register clears
  assign ctl_out   = rst ? '0 : ctl;
  assign reg_dst    = ctl_out.reg_dst;
  assign branch     = ctl_out.branch;
  assign pc_branch  = ctl_out.pc_branch;
  assign mem_read   = ctl_out.mem_read;
  assign mem_to_reg = ctl_out.mem_to_reg;
  assign alu_op     = ctl_out.alu_op;
  assign mem_write  = ctl_out.mem_write;
  assign alu_src    = ctl_out.alu_src;
  assign reg_write  = ctl_out.reg_write;
  assign pc_write   = ctl_out.pc_write;
  assign ir_write   = ctl_out.ir_write;
  assign state_out  = state_q;

endmodule

// File: tb/tb_cs161_control_fsm.sv
// Randomized bench for cs161_control_fsm: each instruction is expanded by the bench
// into its expected per-cycle control trace and compared cycle by cycle.
module tb_cs161_control_fsm;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    instr_op, funct;
  logic          alu_zero, mem_ready;
  logic          reg_dst, branch, pc_branch, mem_read, mem_to_reg;
  logic [3:0]    alu_op;
  logic          mem_write, alu_src, reg_write, pc_write, ir_write;
  logic [2:0]    state_out;
  logic [CW-1:0] instr_retired;
  logic          illegal_op;

  int checks = 0;
  int failures = 0;
  int exp_ret = 0;
  bit exp_ill = 1'b0;

  always #5 clk = ~clk;

  cs161_control_fsm #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .instr_op(instr_op), .funct(funct), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .reg_dst(reg_dst), .branch(branch), .pc_branch(pc_branch),
    .mem_read(mem_read), .mem_to_reg(mem_to_reg), .alu_op(alu_op), .mem_write(mem_write),
    .alu_src(alu_src), .reg_write(reg_write), .pc_write(pc_write), .ir_write(ir_write),
    .state_out(state_out), .instr_retired(instr_retired), .illegal_op(illegal_op)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // {state, reg_dst, branch, pc_branch, mem_read, mem_to_reg, alu_op, mem_write, alu_src,
  //  reg_write, pc_write, ir_write}
  function automatic logic [16:0] pk(input int st, input bit rd, input bit br, input bit pb,
                                     input bit mr, input bit m2r, input logic [3:0] aop,
                                     input bit mw, input bit as, input bit rw,
                                     input bit pw, input bit iw);
    return {st[2:0], rd, br, pb, mr, m2r, aop, mw, as, rw, pw, iw};
  endfunction

  // inputs applied just after a rising edge, outputs sampled on the falling edge
  task automatic cyc(input string tag, input logic [16:0] e, input bit rdy,
                     input logic [5:0] op, input bit z, input bit r);
    logic [16:0] obs;
    mem_ready = rdy; instr_op = op; alu_zero = z; rst = r;
    funct = 6'($urandom);
    @(negedge clk);
    obs = {state_out, reg_dst, branch, pc_branch, mem_read, mem_to_reg, alu_op,
           mem_write, alu_src, reg_write, pc_write, ir_write};
    if (r) chk({tag, "_rst"}, {18'd0, obs[13:0]}, 32'd0);
    else   chk(tag, {15'd0, obs}, {15'd0, e});
    chk("mem_excl", {31'd0, mem_read & mem_write}, 32'd0);
    @(posedge clk); #1;
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h08;
  endfunction

  function automatic logic [5:0] rnd6();
    return 6'($urandom);
  endfunction

  // fw/mw: mem_ready-low cycles in FETCH / MEM; abort: assert rst during the MEM wait
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit abort);
    bit z;
    for (int i = 0; i < fw; i++)
      cyc("fetch_wait", pk(0,0,0,0,1,0,4'd0,0,0,0,0,0), 1'b0, rnd6(), 1'($urandom), 1'b0);
    cyc("fetch", pk(0,0,0,0,1,0,4'd0,0,0,0,1,1), 1'b1, rnd6(), 1'($urandom), 1'b0);
    cyc("decode", pk(1,0,0,0,0,0,4'd0,0,0,0,0,0), 1'($urandom), op, 1'($urandom), 1'b0);
    if (!is_legal(op)) begin
      exp_ill = 1'b1;
    end else begin
      case (op)
        6'h00: begin
          cyc("r_exec", pk(2,0,0,0,0,0,4'd2,0,0,0,0,0), 1'($urandom), rnd6(), 1'($urandom), 1'b0);
          cyc("r_wb", pk(4,1,0,0,0,0,4'd2,0,0,1,0,0), 1'($urandom), rnd6(), 1'($urandom), 1'b0);
          exp_ret++;
        end
        6'h08: begin
          cyc("addi_exec", pk(2,0,0,0,0,0,4'd0,0,1,0,0,0), 1'($urandom), rnd6(), 1'($urandom), 1'b0);
          cyc("addi_wb", pk(4,0,0,0,0,0,4'd0,0,1,1,0,0), 1'($urandom), rnd6(), 1'($urandom), 1'b0);
          exp_ret++;
        end
        6'h04: begin
          z = 1'($urandom);
          cyc("beq_exec", pk(2,0,1,z,0,0,4'd1,0,0,0,0,0), 1'($urandom), rnd6(), z, 1'b0);
          exp_ret++;
        end
        6'h23: begin
          cyc("lw_exec", pk(2,0,0,0,0,0,4'd0,0,1,0,0,0), 1'($urandom), rnd6(), 1'($urandom), 1'b0);
          for (int i = 0; i < mw; i++)
            cyc("lw_mem_wait", pk(3,0,0,0,1,0,4'd0,0,1,0,0,0), 1'b0, rnd6(), 1'($urandom), 1'b0);
          cyc("lw_mem", pk(3,0,0,0,1,0,4'd0,0,1,0,0,0), 1'b1, rnd6(), 1'($urandom), 1'b0);
          cyc("lw_wb", pk(4,0,0,0,0,1,4'd0,0,0,1,0,0), 1'($urandom), rnd6(), 1'($urandom), 1'b0);
          exp_ret++;
        end
        default: begin
          cyc("sw_exec", pk(2,0,0,0,0,0,4'd0,0,1,0,0,0), 1'($urandom), rnd6(), 1'($urandom), 1'b0);
          for (int i = 0; i < mw; i++)
            cyc("sw_mem_wait", pk(3,0,0,0,0,0,4'd0,1,1,0,0,0), 1'b0, rnd6(), 1'($urandom), 1'b0);
          if (abort) begin
            cyc("sw_abort", '0, 1'b0, rnd6(), 1'($urandom), 1'b1);
            rst = 1'b0;
            exp_ret = 0;
            exp_ill = 1'b0;
            chk("abort_state", {29'd0, state_out}, 32'd0);
          end else begin
            cyc("sw_mem", pk(3,0,0,0,0,0,4'd0,1,1,0,0,0), 1'b1, rnd6(), 1'($urandom), 1'b0);
            exp_ret++;
          end
        end
      endcase
    end
    exp_ret = exp_ret % (1 << CW);
    chk("retired", {{(32-CW){1'b0}}, instr_retired}, 32'(exp_ret));
    chk("illegal", {31'd0, illegal_op}, {31'd0, exp_ill});
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] legal_ops [5];
    legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08};
    rst = 1'b1; instr_op = '0; funct = '0; alu_zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    cyc("reset", '0, 1'b1, 6'h23, 1'b1, 1'b1);
    rst = 1'b0;
    chk("reset_state", {29'd0, state_out}, 32'd0);
    chk("reset_retired", {{(32-CW){1'b0}}, instr_retired}, 32'd0);
    chk("reset_illegal", {31'd0, illegal_op}, 32'd0);

    run_instr(6'h00, 0, 0, 1'b0);
    run_instr(6'h23, 0, 2, 1'b0);
    run_instr(6'h04, 0, 0, 1'b0);
    run_instr(6'h04, 1, 0, 1'b0);
    run_instr(6'h3F, 0, 0, 1'b0);
    run_instr(6'h08, 0, 0, 1'b0);
    run_instr(6'h2B, 1, 1, 1'b0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = rnd6(); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 4)];
      end
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    end

    run_instr(6'h2B, 0, 1, 1'b1);
    run_instr(6'h00, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
